// File: rtl/lc3_dmem_access.sv
// LC3 data-memory access unit: services read, write and two-phase indirect
// accesses from the controller against a req/ack data memory with a timeout.
module lc3_dmem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_state,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        complete_data,
  output logic [15:0] DMem_dout,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_IND   = 2'd1;
  localparam logic [1:0] T_WRITE = 2'd2;
  localparam logic [1:0] T_NONE  = 2'd3;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  acc_type;
  logic [7:0]  timer;
  logic [15:0] ptr;
  logic        ind_valid;
  logic        armed;
  logic        accept;
  logic        rearm;

  // A held request type must not retrigger; idle or a new type re-arms.
  assign rearm  = (mem_state == T_NONE) || (mem_state != acc_type);
  assign accept = (state == IDLE) && (mem_state != T_NONE) && armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      acc_type      <= T_NONE;
      timer         <= 8'd0;
      ptr           <= 16'h0000;
      ind_valid     <= 1'b0;
      armed         <= 1'b1;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 16'h0000;
      dmem_wdata    <= 16'h0000;
      complete_data <= 1'b0;
      DMem_dout     <= 16'h0000;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rearm) armed <= 1'b1;
          if (mem_state == T_NONE) ind_valid <= 1'b0;
          if (accept) begin
            state      <= REQ;
            acc_type   <= mem_state;
            dmem_addr  <= ind_valid ? ptr : M_Addr;
            dmem_wdata <= M_Data;
            dmem_we    <= (mem_state == T_WRITE);
            dmem_req   <= 1'b1;
            timer      <= 8'd0;
            mem_err    <= 1'b0;
            ind_valid  <= 1'b0;
          end
        end
        REQ: begin
          // Ack takes priority over expiry in the same cycle.
          if (dmem_ack) begin
            state         <= DONE;
            dmem_req      <= 1'b0;
            complete_data <= 1'b1;
            armed         <= 1'b0;
            if (acc_type == T_READ) DMem_dout <= dmem_rdata;
            if (acc_type == T_IND) begin
              ptr       <= dmem_rdata;
              ind_valid <= 1'b1;
            end
          end else if (timer >= TIMER_LAST) begin
            state         <= DONE;
            dmem_req      <= 1'b0;
            complete_data <= 1'b1;
            armed         <= 1'b0;
            mem_err       <= 1'b1;
            if (acc_type == T_READ) DMem_dout <= 16'h0000;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          complete_data <= 1'b0;
          state         <= IDLE;
          if (rearm) armed <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          dmem_req      <= 1'b0;
          complete_data <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lc3_dmem_access.md
# lc3_dmem_access

Data-memory access unit for the LC3 pipeline. It is the responder end of the controller's `mem_state`/`complete_data` protocol. It takes the access type the controller presents on `mem_state`, runs one read, one write, or a two-phase indirect access against a variable-latency data memory using a req/ack handshake, and returns a one-cycle `complete_data` pulse plus the read data. It sits between the execute stage (address/store data) and the data memory; its read data feeds writeback and the memory bypass path.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `dmem_req` may wait for `dmem_ack` before the access is aborted. Range 1–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_state`  in  2  access type from controller: 0 = read, 1 = indirect pointer read, 2 = write, 3 = idle.
- `M_Addr`  in  16  effective address from execute.
- `M_Data`  in  16  store data from execute.
- `dmem_ack`  in  1  memory handshake acknowledge; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  16  memory read data.
- `dmem_req`  out  1  memory request, held until ack or timeout.
- `dmem_we`  out  1  1 = write, 0 = read; stable while `dmem_req` is high.
- `dmem_addr`  out  16  memory address; stable while `dmem_req` is high.
- `dmem_wdata`  out  16  write data; stable while `dmem_req` is high.
- `complete_data`  out  1  one-cycle completion pulse to the controller.
- `DMem_dout`  out  16  last read result, held until the next read completes.
- `mem_err`  out  1  set by a timed-out access; cleared when the next access is accepted.

## Operation
- FSM states:
  - IDLE → REQ on accept.
  - REQ → DONE on `dmem_ack` or on timeout.
  - DONE → IDLE unconditionally.
- Accept condition in IDLE: `mem_state != 3` and `armed` = 1. On accept the block latches:
  - the type (`mem_state`);
  - the address: `ptr` if `ind_valid` = 1, else `M_Addr`;
  - `M_Data`.
- `armed` behaviour:
  - Cleared on entry to DONE.
  - Set when `mem_state` is 3, or when `mem_state` differs from the type just serviced.
  - Consequence: the controller must present 3 for at least one cycle between two same-type accesses.
- Type 0 (read): `dmem_we` = 0. At ack, `DMem_dout` ← `dmem_rdata`.
- Type 2 (write): `dmem_we` = 1, `dmem_wdata` = latched `M_Data`. `DMem_dout` is unchanged.
- Type 1 (indirect, phase 1): a read at `M_Addr`. At ack, `ptr` ← `dmem_rdata` and `ind_valid` ← 1. `DMem_dout` is unchanged.
  - The controller then presents 0 (LDI) or 2 (STI). That access is accepted via the type change and uses `ptr` as its address.
  - `ind_valid` clears when that access is accepted, and also whenever `mem_state` = 3 is observed in IDLE.
- Changes on `mem_state`, `M_Addr` and `M_Data` while in REQ or DONE are ignored; the latched values are used. `mem_state` = 3 mid-access does not abort the access; `complete_data` still pulses.
- Timeout:
  - A counter clears on accept and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES` the block drops `dmem_req`, sets `mem_err`, goes to DONE, and pulses `complete_data`.
  - A timed-out read loads `DMem_dout` with 16'h0000. A timed-out type 1 leaves `ind_valid` = 0.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- The counter saturates and cannot wrap.

## Timing
- Reset (`rst` = 0, takes effect immediately):
  - FSM → IDLE.
  - `dmem_req`, `dmem_we`, `complete_data`, `mem_err`, `ind_valid` = 0.
  - `DMem_dout`, `dmem_addr`, `dmem_wdata`, `ptr` = 16'h0000.
  - `armed` = 1.
  - An in-flight request is dropped with no completion pulse; a late ack after reset is ignored.
- Accept at edge N: `dmem_req` goes high after edge N.
- Ack sampled at edge M: `dmem_req` drops after M, and `complete_data` is high for exactly the cycle after M. `DMem_dout` is updated at M, so it is valid while `complete_data` is high.
- Minimum latency with ack in the first REQ cycle: accept → `complete_data` = 2 cycles.
- Fastest back-to-back accept is the cycle after DONE, provided `armed` = 1.
- `complete_data` is never high for two consecutive cycles.

## Test plan
- Read: `mem_state` = 0, `M_Addr` = 16'h3010, memory returns 16'hBEEF after 3 cycles → `dmem_req` high for 3 cycles with addr 16'h3010 and `dmem_we` = 0; one `complete_data` pulse; `DMem_dout` = 16'hBEEF.
- Write: `mem_state` = 2, `M_Addr` = 16'h4000, `M_Data` = 16'h1234, ack in 1 cycle → one write with `dmem_we` = 1 and wdata 16'h1234; pulse 2 cycles after accept; `DMem_dout` unchanged.
- LDI: state 1 at 16'h3000 returning 16'h5000, then state 0 → second request addr = 16'h5000; two `complete_data` pulses; `DMem_dout` = data at 16'h5000. Repeat with STI (state 1, then 2) → the write goes to the pointer.
- Re-arm: hold `mem_state` = 0 for 10 cycles → exactly one access. Then 3 for one cycle, then 0 → a second access.
- Timeout: `TIMEOUT_CYCLES` = 4, no ack → `dmem_req` high for 4 cycles; pulse; `mem_err` = 1; `DMem_dout` = 0. Next accepted access clears `mem_err`. Ack on the expiry cycle → no error.
- Reset mid-REQ: assert `rst` low while `dmem_req` = 1 → all outputs at reset values immediately; no `complete_data`; ack after release is ignored.
